// File: rtl/io_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the IO core.
// The slave modport is the arbiter's view; master is the requester/device side.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

interface io_arbiter_if;
  logic                 r0_order;
  logic                 r0_io;
  logic [1:0]           r0_size;
  logic [`LEN_WORD-1:0] r0_o_data;
  logic                 r0_accepted;
  logic                 r0_accessed;
  logic [`LEN_WORD-1:0] r0_i_data;

  logic                 r1_order;
  logic                 r1_io;
  logic [1:0]           r1_size;
  logic [`LEN_WORD-1:0] r1_o_data;
  logic                 r1_accepted;
  logic                 r1_accessed;
  logic [`LEN_WORD-1:0] r1_i_data;

  logic [1:0]           size;
  logic [`LEN_WORD-1:0] io_i_data;
  logic [`LEN_WORD-1:0] io_o_data;
  logic                 io_write_flag;
  logic                 io_read_flag;
  logic                 io_received;
  logic                 busy;

  modport slave (
    input  r0_order, r0_io, r0_size, r0_o_data,
    output r0_accepted, r0_accessed, r0_i_data,
    input  r1_order, r1_io, r1_size, r1_o_data,
    output r1_accepted, r1_accessed, r1_i_data,
    output size, io_i_data, io_write_flag, io_read_flag, busy,
    input  io_o_data, io_received
  );

  modport master (
    output r0_order, r0_io, r0_size, r0_o_data,
    input  r0_accepted, r0_accessed, r0_i_data,
    output r1_order, r1_io, r1_size, r1_o_data,
    input  r1_accepted, r1_accessed, r1_i_data,
    input  size, io_i_data, io_write_flag, io_read_flag, busy,
    output io_o_data, io_received
  );
endinterface

// File: rtl/io_arbiter.sv
// Two-requester round-robin arbiter in front of a single IO core.
// One transfer at a time: IDLE picks a requester and latches its command,
// BUSY holds the command steady until the device strobes io_received.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module io_arbiter (
  input logic         clk,
  input logic         rstn,
  io_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 sel;
  logic                 start;
  logic                 done;

  logic                 grant;
  logic                 last;
  logic [1:0]           size_q;
  logic [`LEN_WORD-1:0] wdata_q;
  logic                 write_q;
  logic                 read_q;
  logic                 r0_accepted_q;
  logic                 r1_accepted_q;
  logic                 r0_accessed_q;
  logic                 r1_accessed_q;
  logic [`LEN_WORD-1:0] r0_rdata_q;
  logic [`LEN_WORD-1:0] r1_rdata_q;

  // Next state, round-robin selection and the start/done events of a transfer
  always_comb begin
    next_state = state;
    sel        = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    if (bus.r0_order && bus.r1_order) begin
      sel = ~last;
    end else begin
      sel = bus.r1_order;
    end
    case (state)
      IDLE: begin
        if (bus.r0_order || bus.r1_order) begin
          start      = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (bus.io_received) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the winner's command on start; drop the device flags on completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant   <= 1'b0;
      last    <= 1'b1;
      size_q  <= 2'd0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else if (start) begin
      grant   <= sel;
      last    <= sel;
      size_q  <= sel ? bus.r1_size : bus.r0_size;
      wdata_q <= sel ? bus.r1_o_data : bus.r0_o_data;
      write_q <= sel ? bus.r1_io : bus.r0_io;
      read_q  <= sel ? ~bus.r1_io : ~bus.r0_io;
    end else if (done) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end
  end

  // One-cycle accepted/accessed pulses toward the requester being served
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_accepted_q <= 1'b0;
      r1_accepted_q <= 1'b0;
      r0_accessed_q <= 1'b0;
      r1_accessed_q <= 1'b0;
    end else begin
      r0_accepted_q <= start && !sel;
      r1_accepted_q <= start && sel;
      r0_accessed_q <= done && !grant;
      r1_accessed_q <= done && grant;
    end
  end

  // Read data is captured only for the granted side when a read completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else if (done && read_q) begin
      if (grant) begin
        r1_rdata_q <= bus.io_o_data;
      end else begin
        r0_rdata_q <= bus.io_o_data;
      end
    end
  end

  assign bus.r0_accepted   = r0_accepted_q;
  assign bus.r1_accepted   = r1_accepted_q;
  assign bus.r0_accessed   = r0_accessed_q;
  assign bus.r1_accessed   = r1_accessed_q;
  assign bus.r0_i_data     = r0_rdata_q;
  assign bus.r1_i_data     = r1_rdata_q;
  assign bus.size          = size_q;
  assign bus.io_i_data     = wdata_q;
  assign bus.io_write_flag = write_q;
  assign bus.io_read_flag  = read_q;
  assign bus.busy          = (state == BUSY);

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: requester commands are queued as expected
// transactions and compared when the arbiter grants and completes them.
module tb_io_arbiter;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk;
  logic        rstn;
  int          checks;
  int          failures;
  txn_t        sbq[$];
  logic [31:0] r0Shadow;
  logic [31:0] r1Shadow;

  io_arbiter_if bus ();

  io_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything waits forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic order, input logic io,
                               input logic [1:0] sz, input logic [31:0] wdata);
    if (req) begin
      bus.r1_order  = order;
      bus.r1_io     = io;
      bus.r1_size   = sz;
      bus.r1_o_data = wdata;
    end else begin
      bus.r0_order  = order;
      bus.r0_io     = io;
      bus.r0_size   = sz;
      bus.r0_o_data = wdata;
    end
  endtask

  task automatic pushExpected(input logic req, input logic wr, input logic [1:0] sz,
                              input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.req   = req;
    t.wr    = wr;
    t.size  = sz;
    t.wdata = wdata;
    t.rdata = rdata;
    sbq.push_back(t);
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_flags"}, 32'({bus.io_write_flag, bus.io_read_flag}), 32'd0);
    checkOutput({tag, "_pulses"}, 32'({bus.r0_accepted, bus.r1_accepted, bus.r0_accessed, bus.r1_accessed}), 32'd0);
  endtask

  task automatic doReset;
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    bus.io_received = 1'b0;
    bus.io_o_data   = 32'd0;
    r0Shadow = 32'd0;
    r1Shadow = 32'd0;
    repeat (2) tick;
    checkIdleQuiet("reset");
    checkOutput("reset_size", 32'(bus.size), 32'd0);
    checkOutput("reset_io_i_data", bus.io_i_data, 32'd0);
    checkOutput("reset_r0_i_data", bus.r0_i_data, 32'd0);
    checkOutput("reset_r1_i_data", bus.r1_i_data, 32'd0);
    rstn = 1'b1;
  endtask

  // Wait for the grant of the next queued transaction, play the device, check completion
  task automatic serveOne(input int latency, input bit dropOrder);
    txn_t exp;
    int   waitCycles;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    exp = sbq.pop_front();
    waitCycles = 0;
    while (!(bus.r0_accepted || bus.r1_accepted) && waitCycles < 20) begin
      tick;
      waitCycles++;
    end
    checkOutput("accept_seen", 32'(bus.r0_accepted || bus.r1_accepted), 32'd1);
    checkOutput("accept_side", 32'({bus.r1_accepted, bus.r0_accepted}), exp.req ? 32'd2 : 32'd1);
    checkOutput("grant_busy", 32'(bus.busy), 32'd1);
    checkOutput("grant_size", 32'(bus.size), 32'(exp.size));
    checkOutput("grant_wdata", bus.io_i_data, exp.wdata);
    checkOutput("grant_flags", 32'({bus.io_write_flag, bus.io_read_flag}), exp.wr ? 32'd2 : 32'd1);
    checkOutput("grant_no_accessed", 32'({bus.r0_accessed, bus.r1_accessed}), 32'd0);
    if (dropOrder) begin
      if (exp.req) bus.r1_order = 1'b0;
      else         bus.r0_order = 1'b0;
    end
    for (int i = 1; i < latency; i++) begin
      tick;
      checkOutput("hold_flags", 32'({bus.io_write_flag, bus.io_read_flag}), exp.wr ? 32'd2 : 32'd1);
      checkOutput("hold_pulses", 32'({bus.r0_accepted, bus.r1_accepted, bus.r0_accessed, bus.r1_accessed}), 32'd0);
    end
    bus.io_o_data   = exp.rdata;
    bus.io_received = 1'b1;
    tick;
    bus.io_received = 1'b0;
    if (!exp.wr) begin
      if (exp.req) r1Shadow = exp.rdata;
      else         r0Shadow = exp.rdata;
    end
    checkOutput("accessed_side", 32'({bus.r1_accessed, bus.r0_accessed}), exp.req ? 32'd2 : 32'd1);
    checkOutput("done_no_accepted", 32'({bus.r0_accepted, bus.r1_accepted}), 32'd0);
    checkOutput("done_flags", 32'({bus.io_write_flag, bus.io_read_flag}), 32'd0);
    checkOutput("done_busy", 32'(bus.busy), 32'd0);
    checkOutput("done_r0_i_data", bus.r0_i_data, r0Shadow);
    checkOutput("done_r1_i_data", bus.r1_i_data, r1Shadow);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    doReset();

    // Single read from r0, size 4 B, device answers after 3 cycles
    $display("[TB] single read");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0000);
    pushExpected(1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF);
    serveOne(3, 1'b1);
    tick;
    checkIdleQuiet("after_read");

    // Single write from r1, size 1 B; r1 read data must stay 0
    $display("[TB] single write");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0041);
    pushExpected(1'b1, 1'b1, 2'd0, 32'h0000_0041, 32'h5555_AAAA);
    serveOne(2, 1'b1);
    checkOutput("write_r1_i_data_zero", bus.r1_i_data, 32'd0);
    tick;

    // Reserved size passes through; completion in the first BUSY cycle
    $display("[TB] reserved size, fastest device");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 32'h1234_5678);
    pushExpected(1'b1, 1'b0, 2'd3, 32'h1234_5678, 32'hCAFE_F00D);
    serveOne(1, 1'b1);
    tick;

    // Spurious strobe in IDLE and an order withdrawn before any edge sees it
    $display("[TB] spurious strobe and withdrawn order");
    bus.io_received = 1'b1;
    bus.io_o_data   = 32'hFFFF_FFFF;
    tick;
    checkIdleQuiet("spurious1");
    tick;
    checkIdleQuiet("spurious2");
    checkOutput("spurious_r0_i_data", bus.r0_i_data, r0Shadow);
    checkOutput("spurious_r1_i_data", bus.r1_i_data, r1Shadow);
    bus.io_received = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 32'h0BAD_0BAD);
    #2;
    bus.r0_order = 1'b0;
    tick;
    checkIdleQuiet("withdrawn1");
    tick;
    checkIdleQuiet("withdrawn2");

    // Continuous contention right after reset: r0, r1, r0, r1
    $display("[TB] contention");
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 32'h1111_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 32'h2222_0000);
    pushExpected(1'b0, 1'b0, 2'd1, 32'h1111_0000, 32'hA000_0001);
    pushExpected(1'b1, 1'b1, 2'd2, 32'h2222_0000, 32'hB000_0001);
    pushExpected(1'b0, 1'b0, 2'd1, 32'h1111_0000, 32'hA000_0002);
    pushExpected(1'b1, 1'b1, 2'd2, 32'h2222_0000, 32'hB000_0002);
    serveOne(2, 1'b0);
    serveOne(3, 1'b0);
    serveOne(1, 1'b0);
    serveOne(2, 1'b0);
    bus.r0_order = 1'b0;
    bus.r1_order = 1'b0;
    tick;
    checkIdleQuiet("contention_end");
    checkOutput("contention_queue_empty", 32'(sbq.size()), 32'd0);

    // Reset during BUSY of an r0 read aborts it
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h0);
    tick;
    checkOutput("abort_accepted", 32'(bus.r0_accepted), 32'd1);
    bus.r0_order = 1'b0;
    tick;
    checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
    checkOutput("abort_read_flag_before", 32'(bus.io_read_flag), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkIdleQuiet("abort_async");
    checkOutput("abort_r0_i_data", bus.r0_i_data, 32'd0);
    r0Shadow = 32'd0;
    r1Shadow = 32'd0;
    tick;
    rstn = 1'b1;
    bus.io_o_data   = 32'h7777_7777;
    bus.io_received = 1'b1;
    tick;
    bus.io_received = 1'b0;
    checkIdleQuiet("late_strobe");
    checkOutput("late_r0_i_data", bus.r0_i_data, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_00AA);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_00BB);
    pushExpected(1'b0, 1'b0, 2'd0, 32'h0000_00AA, 32'h0000_0099);
    serveOne(2, 1'b1);
    bus.r1_order = 1'b0;
    tick;
    checkIdleQuiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
